jt900h_intctl: RTL



---
 rtl/jt900h_intctl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jt900h_intctl.sv
// jt900h_intctl: interrupt controller between NCH peripheral request lines
// and the jt900h CPU irq/ack/vector interface.
//
// Ports:
//   rst      async reset, active high
//   clk      system clock
//   cen      clock enable; all state advances only when high
//   src      raw request lines (NCH)
//   imask    CPU interrupt mask (3 bits)
//   irq      request to the CPU (registered)
//   irq_lvl  level of the presented request
//   irq_vec  vector of the presented request (int_addr)
//   irq_ack  CPU acknowledge, one cen-qualified cycle
//   cra      control-register address
//   crin     control-register write data
//   cr_we    control-register write strobe
//   cr       control-register read data (combinational)
//
// Channel register at CRBASE+n: [2:0] level (0 off, 7 NMI), [3] edge mode,
// [7] pending (write 0 clears, write 1 ignored), [6:4] read as 0.

module jt900h_intctl #(
    parameter int         NCH    = 8,
    parameter logic [7:0] VBASE  = 8'h20,
    parameter logic [7:0] CRBASE = 8'h70
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           cen,
    input  logic [NCH-1:0] src,
    input  logic [2:0]     imask,
    output logic           irq,
    output logic [2:0]     irq_lvl,
    output logic [7:0]     irq_vec,
    input  logic           irq_ack,
    input  logic [7:0]     cra,
    input  logic [7:0]     crin,
    input  logic           cr_we,
    output logic [7:0]     cr
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] src_l_q;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] mode_q;
    logic [2:0]     lvl_q [NCH];
    logic           irq_q;
    logic [2:0]     irq_lvl_q;
    logic [7:0]     irq_vec_q;
    logic [CW-1:0]  chan_q;

    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] elig;
    logic           any_elig;
    logic [CW-1:0]  win_idx;
    logic [2:0]     win_lvl;
    logic [7:0]     win_vec;
    logic           ack_clr;

    logic           unused_crin;
    assign unused_crin = ^crin[6:4];

    assign irq     = irq_q;
    assign irq_lvl = irq_lvl_q;
    assign irq_vec = irq_vec_q;

    // Only an ack seen while presenting a request clears anything.
    assign ack_clr = cen & irq_ack & (state_q == REQ);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = cen & cr_we & (cra == CRBASE + 8'(i));
            elig[i]   = pend_q[i] & (lvl_q[i] != 3'd0) &
                        ((lvl_q[i] > imask) | (lvl_q[i] == 3'd7));
        end
    end

    // Strict '>' keeps the lowest index on equal levels.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        win_lvl  = 3'd0;
        win_vec  = VBASE;
        for (int i = 0; i < NCH; i++) begin
            if (elig[i] && (!any_elig || lvl_q[i] > win_lvl)) begin
                any_elig = 1'b1;
                win_idx  = CW'(i);
                win_lvl  = lvl_q[i];
                win_vec  = VBASE + 8'(4 * i);
            end
        end
    end

    // Level channels follow src so pending always equals src_l after the
    // edge. Edge channels: a new rising edge beats any same-cycle clear.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (!mode_q[i]) begin
                pend_d[i] = src[i];
            end else begin
                pend_d[i] = pend_q[i];
                if (wr_hit[i] && !crin[7]) pend_d[i] = 1'b0;
                if (ack_clr && chan_q == CW'(i)) pend_d[i] = 1'b0;
                if (src[i] && !src_l_q[i]) pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cr = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            if (cra == CRBASE + 8'(i))
                cr = {pend_q[i], 3'b000, mode_q[i], lvl_q[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_l_q   <= '0;
            pend_q    <= '0;
            mode_q    <= '0;
            irq_q     <= 1'b0;
            irq_lvl_q <= 3'd0;
            irq_vec_q <= 8'd0;
            chan_q    <= '0;
            for (int i = 0; i < NCH; i++) lvl_q[i] <= 3'd0;
        end else if (cen) begin
            src_l_q <= src;
            pend_q  <= pend_d;
            for (int i = 0; i < NCH; i++) begin
                if (wr_hit[i]) begin
                    lvl_q[i]  <= crin[2:0];
                    mode_q[i] <= crin[3];
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        chan_q    <= win_idx;
                        irq_lvl_q <= win_lvl;
                        irq_vec_q <= win_vec;
                        irq_q     <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irq_q   <= 1'b0;
                        state_q <= ACK;
                    end else if (!any_elig) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        // Relatch every cycle: covers preemption, loss of
                        // the current channel and level rewrites alike.
                        chan_q    <= win_idx;
                        irq_lvl_q <= win_lvl;
                        irq_vec_q <= win_vec;
                    end
                end
                ACK: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
